// File: rtl/io_board_responder.sv
// Bus-addressed I/O board: synchronized strobes, debounced field inputs,
// latched field outputs and a watchdog that forces outputs safe when writes stop.
module io_board_responder #(
    parameter logic [3:0] BOARD_ADDR      = 4'd0,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         WATCHDOG_CYCLES = 1000000,
    parameter logic [7:0] OUT_SAFE        = 8'h00
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [3:0] io_address,
    input  logic [1:0] io_enable_n,
    inout  wire  [7:0] io_data,
    input  logic [7:0] board_inputs,
    output logic [7:0] board_outputs,
    output logic       bus_active,
    output logic       wdt_expired
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam int WDT_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WATCHDOG_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ERROR} state_t;

    logic [3:0] addr_s1_q, addr_s2_q;
    logic [1:0] en_s1_q, en_s2_q, en_prev_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic [7:0] in_s1_q, in_s2_q;
    logic [7:0] db_word;

    // en_prev_q resets low, so a strobe held low through reset never looks like a fresh edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            en_s1_q   <= '0;
            en_s2_q   <= '0;
            en_prev_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            in_s1_q   <= '0;
            in_s2_q   <= '0;
        end else begin
            addr_s1_q <= io_address;
            addr_s2_q <= addr_s1_q;
            en_s1_q   <= io_enable_n;
            en_s2_q   <= en_s1_q;
            en_prev_q <= en_s2_q;
            data_s1_q <= io_data;
            data_s2_q <= data_s1_q;
            in_s1_q   <= board_inputs;
            in_s2_q   <= in_s1_q;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_q;
        logic            bit_q;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                cnt_q <= '0;
                bit_q <= 1'b0;
            end else if (in_s2_q[gi] == bit_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q <= '0;
                bit_q <= in_s2_q[gi];
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end

        assign db_word[gi] = bit_q;
    end

    state_t           state_q, state_d;
    logic [7:0]       snap_q, snap_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       out_q;
    logic             expired_q;
    logic [WDT_W-1:0] wdt_cnt_q;
    logic             rd_fall, wr_fall, both_low, addr_hit, write_done;

    assign rd_fall  = en_prev_q[0] & ~en_s2_q[0];
    assign wr_fall  = en_prev_q[1] & ~en_s2_q[1];
    assign both_low = ~en_s2_q[0] & ~en_s2_q[1];
    assign addr_hit = (addr_s2_q == BOARD_ADDR);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        hold_d     = hold_q;
        write_done = 1'b0;
        if (both_low) begin
            state_d = S_ERROR;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rd_fall && en_s2_q[1] && addr_hit) begin
                        state_d = S_READ;
                        snap_d  = db_word;
                    end else if (wr_fall && en_s2_q[0] && addr_hit) begin
                        state_d = S_WRITE;
                        hold_d  = data_s2_q;
                    end
                end
                S_READ: begin
                    if (en_s2_q[0]) state_d = S_IDLE;
                end
                S_WRITE: begin
                    if (en_s2_q[1]) begin
                        state_d    = S_IDLE;
                        write_done = 1'b1;
                    end else begin
                        hold_d = data_s2_q;
                    end
                end
                S_ERROR: begin
                    if (en_s2_q == 2'b11) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A completed write both refreshes the outputs and feeds the watchdog.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            hold_q    <= '0;
            out_q     <= OUT_SAFE;
            expired_q <= 1'b0;
            wdt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            hold_q  <= hold_d;
            if (write_done) begin
                out_q     <= hold_q;
                expired_q <= 1'b0;
                wdt_cnt_q <= '0;
            end else if (WATCHDOG_CYCLES > 0 && wdt_cnt_q != WDT_MAX) begin
                wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
                if (wdt_cnt_q + WDT_W'(1) == WDT_MAX) begin
                    out_q     <= OUT_SAFE;
                    expired_q <= 1'b1;
                end
            end
        end
    end

    assign bus_active    = (state_q == S_READ) || (state_q == S_WRITE);
    assign board_outputs = out_q;
    assign wdt_expired   = expired_q;
    assign io_data       = (state_q == S_READ && !en_s2_q[0] && en_s2_q[1]) ? snap_q : 8'bz;

endmodule

// File: tb/tb_io_board_responder.sv
// Randomized bench for io_board_responder: stimulus queues expected bus results,
// a negedge monitor pops them when the board goes active and checks the outputs.
`timescale 1ns/1ps
module tb_io_board_responder;

    localparam logic [3:0] ADDR  = 4'd3;
    localparam int         WDT   = 100;
    localparam logic [7:0] SAFE  = 8'h00;
    localparam logic [7:0] FLOAT = 8'hFF;

    typedef enum logic [1:0] {K_READ, K_WRITE, K_ABORT} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [7:0] data;
    } exp_t;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] io_address;
    logic [1:0] io_enable_n;
    logic [7:0] board_inputs;
    logic [7:0] tb_data;
    logic       tb_den;
    tri1  [7:0] io_data;
    logic [7:0] board_outputs;
    logic       bus_active;
    logic       wdt_expired;

    assign io_data = tb_den ? tb_data : 8'bz;

    io_board_responder #(
        .BOARD_ADDR     (ADDR),
        .DEBOUNCE_CYCLES(16),
        .WATCHDOG_CYCLES(WDT),
        .OUT_SAFE       (SAFE)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .io_address   (io_address),
        .io_enable_n  (io_enable_n),
        .io_data      (io_data),
        .board_inputs (board_inputs),
        .board_outputs(board_outputs),
        .bus_active   (bus_active),
        .wdt_expired  (wdt_expired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    exp_t       exp_q[$];
    exp_t       cur;
    bit         in_tx;
    bit         prev_active;
    bit         mon_done;
    int         idle;        // cycles since last completed write (or reset), capped at WDT
    logic [7:0] model_out;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            in_tx       = 1'b0;
            prev_active = 1'b0;
            idle        = 0;
            model_out   = SAFE;
        end else begin
            mon_done = 1'b0;
            if (bus_active && !prev_active) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", {7'd0, bus_active}, 8'd0);
                end else begin
                    cur   = exp_q.pop_front();
                    in_tx = 1'b1;
                    if (cur.kind == K_READ) check("read_data", io_data, cur.data);
                end
            end else if (!bus_active && prev_active && in_tx) begin
                in_tx = 1'b0;
                if (cur.kind == K_WRITE) begin
                    model_out = cur.data;
                    idle      = 0;
                    mon_done  = 1'b1;
                end
            end
            if (!mon_done) begin
                if (idle < WDT) idle++;
                if (idle >= WDT) model_out = SAFE;
            end
            check("board_outputs", board_outputs, model_out);
            check("wdt_expired", {7'd0, wdt_expired}, {7'd0, idle >= WDT});
            if (!(bus_active && in_tx && cur.kind == K_READ))
                check("bus_idle_value", io_data, tb_den ? tb_data : FLOAT);
            prev_active = bus_active;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] stable;      // word the board should report once debouncing has settled

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic bus_tx(input logic [3:0] addr, input logic [1:0] en, input logic [7:0] data, input int len);
        io_address  = addr;
        io_enable_n = en;
        tb_data     = data;
        tb_den      = (en == 2'b01);
        tick(2);
        io_address  = 4'($urandom);
        tick(len - 2);
        io_enable_n = 2'b11;
        tb_den      = 1'b0;
        tick(4);
    endtask

    task automatic do_read(input int len);
        exp_q.push_back('{kind: K_READ, data: stable});
        bus_tx(ADDR, 2'b10, 8'h00, len);
    endtask

    task automatic do_write(input logic [7:0] d, input int len);
        exp_q.push_back('{kind: K_WRITE, data: d});
        bus_tx(ADDR, 2'b01, d, len);
    endtask

    task automatic new_word(input logic [7:0] w);
        board_inputs = w;
        tick(20);
        stable = w;
    endtask

    task automatic glitch(input logic [7:0] mask, input int len);
        board_inputs = board_inputs ^ mask;
        tick(len);
        board_inputs = board_inputs ^ mask;
        tick(3);
    endtask

    initial begin
        Rst_n        = 1'b0;
        io_address   = 4'd0;
        io_enable_n  = 2'b11;
        board_inputs = 8'h00;
        tb_data      = 8'h00;
        tb_den       = 1'b0;
        stable       = 8'h00;
        tick(3);
        check("reset_outputs", board_outputs, SAFE);
        check("reset_bus_active", {7'd0, bus_active}, 8'd0);
        check("reset_wdt", {7'd0, wdt_expired}, 8'd0);
        check("reset_bus_float", io_data, FLOAT);
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        tick(1);

        new_word(8'hA5);
        do_read(5);
        do_write(8'h3C, 10);
        bus_tx(4'd5, 2'b10, 8'h00, 5);
        bus_tx(4'd5, 2'b01, 8'hC3, 6);
        glitch(8'h01, 5);
        do_read(4);
        new_word(8'hA4);
        do_read(4);
        do_write(8'hFF, 5);
        tick(105);
        check("wdt_safe_outputs", board_outputs, SAFE);
        check("wdt_flag_set", {7'd0, wdt_expired}, 8'd1);
        do_write(8'h11, 5);
        check("wdt_flag_clear", {7'd0, wdt_expired}, 8'd0);
        bus_tx(ADDR, 2'b00, 8'h00, 4);
        exp_q.push_back('{kind: K_ABORT, data: 8'h00});
        io_address = ADDR; io_enable_n = 2'b01; tb_data = 8'h77; tb_den = 1'b1;
        tick(3);
        io_enable_n = 2'b00;
        tick(3);
        io_enable_n = 2'b11; tb_den = 1'b0;
        tick(4);

        repeat (90) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12)      new_word(8'($urandom));
            else if (r < 22) glitch(8'($urandom_range(1, 255)), $urandom_range(1, 8));
            else if (r < 42) do_read($urandom_range(3, 8));
            else if (r < 62) do_write(8'($urandom), $urandom_range(3, 10));
            else if (r < 72) bus_tx(ADDR ^ 4'($urandom_range(1, 15)),
                                    ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 8'($urandom), 5);
            else if (r < 80) bus_tx(4'($urandom), 2'b00, 8'($urandom), $urandom_range(3, 6));
            else if (r < 94) tick($urandom_range(1, 10));
            else             tick($urandom_range(100, 130));
        end

        // Reset in the middle of a read, with the strobe still held low afterwards.
        do_write(8'h5A, 5);
        exp_q.push_back('{kind: K_READ, data: stable});
        io_address  = ADDR;
        io_enable_n = 2'b10;
        tick(4);
        Rst_n = 1'b0;
        #1;
        check("rst_mid_read_float", io_data, FLOAT);
        check("rst_mid_read_outputs", board_outputs, SAFE);
        check("rst_mid_read_active", {7'd0, bus_active}, 8'd0);
        tick(2);
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        tick(10);
        io_enable_n = 2'b11;
        tick(25);
        do_read(5);
        do_write(8'h96, 5);
        tick(5);

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_board_responder.md
IO_BOARD_RESPONDER -- requirements
Module: io_board_responder

Interface
REQ-001 Parameter BOARD_ADDR, default 4'd0: bus address this board answers to.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable Clk cycles before an input bit is accepted.
REQ-003 Parameter WATCHDOG_CYCLES, default 1000000: Clk cycles without a matching write before outputs go safe; 0 disables.
REQ-004 Parameter OUT_SAFE, default 8'h00: output value at reset and on watchdog expiry.
REQ-005 Clk  input  1  board clock; one clock, all logic on rising edge.
REQ-006 Rst_n  input  1  reset, asynchronous, active-low.
REQ-007 io_address  input  4  board select from the bus controller.
REQ-008 io_enable_n  input  2  bit0 low = read strobe (board drives io_data); bit1 low = write strobe (controller drives io_data).
REQ-009 io_data  inout  8  shared data bus; driven only during a matched read, otherwise high-Z.
REQ-010 board_inputs  input  8  raw asynchronous field inputs.
REQ-011 board_outputs  output  8  latched field outputs.
REQ-012 bus_active  output  1  high while in READ or WRITE state.
REQ-013 wdt_expired  output  1  high while outputs are forced safe by the watchdog.

Function
REQ-014 io_address, io_enable_n and io_data SHALL each pass through a 2-flop synchronizer; all decisions use synchronized values.
REQ-015 Each board_inputs bit SHALL be 2-flop synchronized, then debounced: the accepted bit changes only after DEBOUNCE_CYCLES consecutive cycles at the new level.
REQ-016 FSM states SHALL be IDLE, READ, WRITE, ERROR.
REQ-017 IDLE->READ on a synced falling edge of enable_n[0] with enable_n[1] high and synced address == BOARD_ADDR; the debounced input word SHALL be snapshotted in that same cycle.
REQ-018 In READ, io_data SHALL be driven with the snapshot starting the cycle after entry; the drive is released (high-Z) in the cycle that synced enable_n[0] is seen high, with return to IDLE.
REQ-019 IDLE->WRITE on a synced falling edge of enable_n[1] with enable_n[0] high and address match; each WRITE cycle SHALL capture synced io_data into a holding register.
REQ-020 On synced enable_n[1] returning high in WRITE, board_outputs SHALL load the holding register on the next edge, the watchdog counter clears, and the FSM returns to IDLE.
REQ-021 Address is evaluated only at strobe start; address changes during READ/WRITE SHALL be ignored.
REQ-022 Both synced strobes low at once, from any state, SHALL enter ERROR: drive released, no output update; exit to IDLE only when both strobes are high.
REQ-023 A strobe falling edge with a non-matching address SHALL leave the FSM in IDLE and io_data high-Z.
REQ-024 Watchdog (WATCHDOG_CYCLES>0): counter increments every cycle not completing a matched write; on reaching WATCHDOG_CYCLES it saturates, board_outputs = OUT_SAFE, wdt_expired = 1.
REQ-025 wdt_expired SHALL clear in the same cycle board_outputs loads a new written value.
REQ-026 Reads SHALL NOT reset the watchdog.

Reset
REQ-027 Rst_n low SHALL immediately (asynchronously) release io_data to high-Z and force state IDLE, board_outputs = OUT_SAFE, bus_active = 0, wdt_expired = 0, watchdog count 0, synchronizers and debounced inputs 0.
REQ-028 Reset asserted mid-READ or mid-WRITE SHALL abort the transaction with no output update; after release, a strobe already low SHALL NOT start a transaction until it has been seen high then low.

Verification
REQ-029 BOARD_ADDR=3, board_inputs=8'hA5 held 20 cycles; address=3, enable_n=2'b10 -> io_data=8'hA5 within 4 cycles; strobe high -> high-Z within 3 cycles.
REQ-030 Address=3, io_data=8'h3C, enable_n=2'b01 for 10 cycles then 2'b11 -> board_outputs=8'h3C within 4 cycles, io_data never driven by DUT.
REQ-031 Address=5 read and write strobes -> io_data stays high-Z, board_outputs unchanged.
REQ-032 board_inputs bit0 glitch lasting 5 cycles (DEBOUNCE_CYCLES=16) -> read returns bit0 unchanged; step held 20 cycles -> read returns new value.
REQ-033 WATCHDOG_CYCLES=100, write 8'hFF then idle 100 cycles -> board_outputs=8'h00, wdt_expired=1; next write 8'h11 -> board_outputs=8'h11, wdt_expired=0.
REQ-034 enable_n=2'b00 -> ERROR, no drive, no update; Rst_n pulsed during READ -> io_data high-Z same cycle, board_outputs=OUT_SAFE.
